// File: rtl/bp_me_mem_cmd_arbiter_2to1.sv
// Two-to-one BedRock mem command arbiter with in-order response steering.
// Commands from two requesters are round-robin arbitrated onto one memory
// port. The granted requester id goes into an in-order tracking FIFO, and
// the id at the FIFO head steers each in-order response back to its issuer.
//
// Handshakes: command ports are ready-and-valid. A transfer happens on a
// cycle where valid and ready are both high, and ready may depend on valid.
// Response ports are valid-yumi. A consumer raises yumi only while the
// matching valid is high, and the transfer happens in that same cycle.
module bp_me_mem_cmd_arbiter_2to1 #(
  parameter int mem_msg_width_p   = 64,
  parameter int outstanding_els_p = 4,
  localparam int lg_outstanding_lp = $clog2(outstanding_els_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic [mem_msg_width_p-1:0]   mem_cmd0_i,
  input  logic                         mem_cmd0_v_i,
  output logic                         mem_cmd0_ready_o,
  input  logic [mem_msg_width_p-1:0]   mem_cmd1_i,
  input  logic                         mem_cmd1_v_i,
  output logic                         mem_cmd1_ready_o,

  output logic [mem_msg_width_p-1:0]   mem_cmd_o,
  output logic                         mem_cmd_v_o,
  input  logic                         mem_cmd_ready_i,

  input  logic [mem_msg_width_p-1:0]   mem_resp_i,
  input  logic                         mem_resp_v_i,
  output logic                         mem_resp_yumi_o,

  output logic [mem_msg_width_p-1:0]   mem_resp0_o,
  output logic                         mem_resp0_v_o,
  input  logic                         mem_resp0_yumi_i,
  output logic [mem_msg_width_p-1:0]   mem_resp1_o,
  output logic                         mem_resp1_v_o,
  input  logic                         mem_resp1_yumi_i,

  output logic [lg_outstanding_lp-1:0] outstanding_o,
  output logic                         error_o
);

  localparam int ptr_w_lp = $clog2(outstanding_els_p);

  logic [outstanding_els_p-1:0] id_mem_r;
  logic [ptr_w_lp-1:0]          wptr_r, rptr_r;
  logic [lg_outstanding_lp-1:0] count_r;
  logic                         last_grant_r;
  logic                         error_r;

  logic full, empty, can_issue, grant, push, pop, head, resp_ok;

  assign full  = (count_r == lg_outstanding_lp'(outstanding_els_p));
  assign empty = (count_r == '0);

  // The reset term forces every handshake output low while reset is held,
  // without waiting for a clock edge.
  assign can_issue = reset_n_i & mem_cmd_ready_i & ~full;

  // Round-robin grant: a contested cycle goes to the requester not served last.
  always_comb begin
    grant = 1'b0;
    if (mem_cmd0_v_i && mem_cmd1_v_i) grant = ~last_grant_r;
    else if (mem_cmd1_v_i)            grant = 1'b1;
  end

  assign mem_cmd_v_o      = can_issue & (mem_cmd0_v_i | mem_cmd1_v_i);
  assign mem_cmd_o        = grant ? mem_cmd1_i : mem_cmd0_i;
  assign mem_cmd0_ready_o = can_issue & ~grant & mem_cmd0_v_i;
  assign mem_cmd1_ready_o = can_issue &  grant & mem_cmd1_v_i;
  assign push             = mem_cmd_v_o;

  // A response is routed only when some command is tracked. A stray response
  // is left at the input and flags the error.
  assign head            = id_mem_r[rptr_r];
  assign resp_ok         = reset_n_i & mem_resp_v_i & ~empty;
  assign mem_resp0_v_o   = resp_ok & ~head;
  assign mem_resp1_v_o   = resp_ok &  head;
  assign mem_resp0_o     = mem_resp_i;
  assign mem_resp1_o     = mem_resp_i;
  assign mem_resp_yumi_o = head ? (mem_resp1_v_o & mem_resp1_yumi_i)
                                : (mem_resp0_v_o & mem_resp0_yumi_i);
  assign pop             = mem_resp_yumi_o;

  assign outstanding_o = count_r;
  assign error_o       = error_r;

  // Tracking FIFO, occupancy count, round-robin history and sticky error flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      id_mem_r     <= '0;
      wptr_r       <= '0;
      rptr_r       <= '0;
      count_r      <= '0;
      last_grant_r <= 1'b1;
      error_r      <= 1'b0;
    end else begin
      if (push) begin
        id_mem_r[wptr_r] <= grant;
        wptr_r           <= wptr_r + ptr_w_lp'(1);
        last_grant_r     <= grant;
      end
      if (pop) rptr_r <= rptr_r + ptr_w_lp'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + lg_outstanding_lp'(1);
        2'b01:   count_r <= count_r - lg_outstanding_lp'(1);
        default: count_r <= count_r;
      endcase
      if (mem_resp_v_i && empty) error_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter_2to1.sv
// Directed bench for the 2:1 mem command arbiter. The stimulus pushes the
// expected commands and responses into queues, and a negedge monitor pops
// and compares them whenever the DUT presents a transfer.
module tb_bp_me_mem_cmd_arbiter_2to1;
  localparam int W = 16;
  localparam int N = 4;
  localparam int LG = $clog2(N + 1);

  logic clk = 1'b0;
  logic reset_n_i;
  logic [W-1:0] mem_cmd0_i, mem_cmd1_i, mem_cmd_o, mem_resp_i, mem_resp0_o, mem_resp1_o;
  logic mem_cmd0_v_i, mem_cmd0_ready_o, mem_cmd1_v_i, mem_cmd1_ready_o;
  logic mem_cmd_v_o, mem_cmd_ready_i, mem_resp_v_i, mem_resp_yumi_o;
  logic mem_resp0_v_o, mem_resp0_yumi_i, mem_resp1_v_o, mem_resp1_yumi_i;
  logic [LG-1:0] outstanding_o;
  logic error_o;
  logic yumi_en0, yumi_en1;

  int checks = 0;
  int errors = 0;

  // Each command entry is {ready1, ready0, cmd}, so the grant is checked together with the data.
  logic [W+1:0] exp_cmd_q[$];
  logic [W-1:0] exp_r0_q[$];
  logic [W-1:0] exp_r1_q[$];

  bp_me_mem_cmd_arbiter_2to1 #(.mem_msg_width_p(W), .outstanding_els_p(N)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .mem_cmd0_i(mem_cmd0_i), .mem_cmd0_v_i(mem_cmd0_v_i), .mem_cmd0_ready_o(mem_cmd0_ready_o),
    .mem_cmd1_i(mem_cmd1_i), .mem_cmd1_v_i(mem_cmd1_v_i), .mem_cmd1_ready_o(mem_cmd1_ready_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .mem_resp0_o(mem_resp0_o), .mem_resp0_v_o(mem_resp0_v_o), .mem_resp0_yumi_i(mem_resp0_yumi_i),
    .mem_resp1_o(mem_resp1_o), .mem_resp1_v_o(mem_resp1_v_o), .mem_resp1_yumi_i(mem_resp1_yumi_i),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  // Clock and requester consume behaviour: yumi follows valid when enabled.
  always #5 clk = ~clk;
  assign mem_resp0_yumi_i = mem_resp0_v_o & yumi_en0;
  assign mem_resp1_yumi_i = mem_resp1_v_o & yumi_en1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_cmd(input logic id, input logic [W-1:0] d);
    exp_cmd_q.push_back({id, ~id, d});
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    mem_cmd0_i = '0; mem_cmd1_i = '0; mem_resp_i = '0;
    mem_cmd0_v_i = 1'b0; mem_cmd1_v_i = 1'b0; mem_resp_v_i = 1'b0;
    mem_cmd_ready_i = 1'b1; yumi_en0 = 1'b1; yumi_en1 = 1'b1;
    @(negedge clk);
    check("rst_outstanding", 32'(outstanding_o), 0);
    check("rst_error", 32'(error_o), 0);
    check("rst_cmd_v", 32'(mem_cmd_v_o), 0);
    tick();
    reset_n_i = 1'b1;
  endtask

  // Drive one memory response and hold it until the arbiter consumes it.
  task automatic send_resp(input logic [W-1:0] d, input logic id);
    logic got;
    if (id) exp_r1_q.push_back(d);
    else    exp_r0_q.push_back(d);
    mem_resp_i = d;
    mem_resp_v_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = mem_resp_yumi_o;
      tick();
    end
    mem_resp_v_i = 1'b0;
    check("resp_consumed", 32'(got), 1);
  endtask

  // Monitor: every presented transfer must match the head of its expected queue.
  always @(negedge clk) begin
    if (reset_n_i === 1'b1) begin
      if (mem_cmd_v_o) begin
        if (exp_cmd_q.size() == 0) check("cmd_unexpected", 32'(mem_cmd_o), 32'hdead);
        else check("cmd_out", 32'({mem_cmd1_ready_o, mem_cmd0_ready_o, mem_cmd_o}), 32'(exp_cmd_q.pop_front()));
      end
      if (mem_resp0_v_o && mem_resp0_yumi_i) begin
        check("resp0_yumi", 32'(mem_resp_yumi_o), 1);
        if (exp_r0_q.size() == 0) check("resp0_unexpected", 32'(mem_resp0_o), 32'hdead);
        else check("resp0_data", 32'(mem_resp0_o), 32'(exp_r0_q.pop_front()));
      end
      if (mem_resp1_v_o && mem_resp1_yumi_i) begin
        check("resp1_yumi", 32'(mem_resp_yumi_o), 1);
        if (exp_r1_q.size() == 0) check("resp1_unexpected", 32'(mem_resp1_o), 32'hdead);
        else check("resp1_data", 32'(mem_resp1_o), 32'(exp_r1_q.pop_front()));
      end
    end
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    logic [7:0] n0, n1;
    do_reset();

    // 1: req0 alone issues A, B, C; all responses return to req0.
    mem_cmd0_v_i = 1'b1;
    mem_cmd0_i = 16'hA001; exp_cmd(0, 16'hA001); tick();
    mem_cmd0_i = 16'hA002; exp_cmd(0, 16'hA002); tick();
    mem_cmd0_i = 16'hA003; exp_cmd(0, 16'hA003); tick();
    mem_cmd0_v_i = 1'b0;
    @(negedge clk); check("t1_outstanding3", 32'(outstanding_o), 3); tick();
    send_resp(16'hB001, 0);
    send_resp(16'hB002, 0);
    send_resp(16'hB003, 0);
    @(negedge clk); check("t1_outstanding0", 32'(outstanding_o), 0); tick();

    // 2 and 3: both requesters valid, grants alternate 0,1,0,1 from reset, then fill to depth.
    do_reset();
    n0 = 0; n1 = 0;
    mem_cmd0_v_i = 1'b1; mem_cmd1_v_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_cmd0_i = 16'h0100 + 16'(n0);
      mem_cmd1_i = 16'h0200 + 16'(n1);
      if (i % 2 == 0) exp_cmd(0, mem_cmd0_i);
      else            exp_cmd(1, mem_cmd1_i);
      tick();
      if (i % 2 == 0) n0++;
      else            n1++;
    end
    mem_cmd0_i = 16'h0102; mem_cmd1_i = 16'h0202;
    @(negedge clk);
    check("full_cmd_v", 32'(mem_cmd_v_o), 0);
    check("full_ready0", 32'(mem_cmd0_ready_o), 0);
    check("full_ready1", 32'(mem_cmd1_ready_o), 0);
    check("full_outstanding", 32'(outstanding_o), 4);
    tick();
    // A pop while full must not let a push in on the same cycle.
    mem_resp_i = 16'h5000; mem_resp_v_i = 1'b1; exp_r0_q.push_back(16'h5000);
    @(negedge clk);
    check("full_pop_yumi", 32'(mem_resp_yumi_o), 1);
    check("full_pop_ready0", 32'(mem_cmd0_ready_o), 0);
    check("full_pop_outstanding", 32'(outstanding_o), 4);
    tick();
    // Push and pop together leave the count unchanged.
    exp_cmd(0, 16'h0102);
    mem_resp_i = 16'h5001; exp_r1_q.push_back(16'h5001);
    @(negedge clk); check("pushpop_outstanding_a", 32'(outstanding_o), 3); tick();
    mem_cmd0_i = 16'h0103;
    exp_cmd(1, 16'h0202);
    mem_resp_i = 16'h5002; exp_r0_q.push_back(16'h5002);
    @(negedge clk); check("pushpop_outstanding_b", 32'(outstanding_o), 3); tick();
    mem_cmd0_v_i = 1'b0; mem_cmd1_v_i = 1'b0; mem_resp_v_i = 1'b0;
    @(negedge clk); check("pushpop_outstanding_c", 32'(outstanding_o), 3); tick();
    send_resp(16'h5003, 1);
    send_resp(16'h5004, 0);
    send_resp(16'h5005, 1);
    @(negedge clk); check("t2_outstanding0", 32'(outstanding_o), 0); tick();

    // 4: memory not ready, so nothing fires and the round-robin history holds.
    mem_cmd0_v_i = 1'b1; mem_cmd0_i = 16'h0300; exp_cmd(0, 16'h0300); tick();
    mem_cmd_ready_i = 1'b0;
    mem_cmd1_v_i = 1'b1; mem_cmd0_i = 16'h0301; mem_cmd1_i = 16'h0400;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_cmd_v", 32'(mem_cmd_v_o), 0);
      check("stall_ready0", 32'(mem_cmd0_ready_o), 0);
      check("stall_ready1", 32'(mem_cmd1_ready_o), 0);
      tick();
    end
    mem_cmd_ready_i = 1'b1;
    exp_cmd(1, 16'h0400); tick();
    mem_cmd0_v_i = 1'b0; mem_cmd1_v_i = 1'b0;
    send_resp(16'h6000, 0);
    send_resp(16'h6001, 1);
    @(negedge clk); check("t4_outstanding0", 32'(outstanding_o), 0); tick();

    // 5: a response with nothing outstanding is not routed and sets the sticky error.
    mem_resp_i = 16'hEEEE; mem_resp_v_i = 1'b1;
    @(negedge clk);
    check("stray_yumi", 32'(mem_resp_yumi_o), 0);
    check("stray_resp0_v", 32'(mem_resp0_v_o), 0);
    check("stray_resp1_v", 32'(mem_resp1_v_o), 0);
    check("stray_error_before", 32'(error_o), 0);
    tick();
    mem_resp_v_i = 1'b0;
    @(negedge clk); check("stray_error_set", 32'(error_o), 1); tick();
    @(negedge clk); check("stray_error_sticky", 32'(error_o), 1); tick();

    // 6: asynchronous reset mid-flight clears everything at once; afterwards req0 wins first.
    do_reset();
    mem_cmd0_v_i = 1'b1;
    mem_cmd0_i = 16'h0700; exp_cmd(0, 16'h0700); tick();
    mem_cmd0_i = 16'h0701; exp_cmd(0, 16'h0701); tick();
    mem_cmd0_i = 16'h0702; exp_cmd(0, 16'h0702); tick();
    mem_cmd1_v_i = 1'b1; mem_cmd0_i = 16'h0703; mem_cmd1_i = 16'h0800;
    mem_resp_i = 16'h7777; mem_resp_v_i = 1'b1;
    #2;
    reset_n_i = 1'b0;
    #1;
    check("midrst_cmd_v", 32'(mem_cmd_v_o), 0);
    check("midrst_ready0", 32'(mem_cmd0_ready_o), 0);
    check("midrst_ready1", 32'(mem_cmd1_ready_o), 0);
    check("midrst_resp0_v", 32'(mem_resp0_v_o), 0);
    check("midrst_yumi", 32'(mem_resp_yumi_o), 0);
    check("midrst_outstanding", 32'(outstanding_o), 0);
    tick();
    mem_resp_v_i = 1'b0;
    reset_n_i = 1'b1;
    exp_cmd(0, 16'h0703);
    @(negedge clk); check("postrst_outstanding", 32'(outstanding_o), 0); tick();
    mem_cmd0_v_i = 1'b0; mem_cmd1_v_i = 1'b0;
    send_resp(16'h7000, 0);
    @(negedge clk); check("t6_outstanding0", 32'(outstanding_o), 0); tick();

    check("cmd_q_left", 32'(exp_cmd_q.size()), 0);
    check("r0_q_left", 32'(exp_r0_q.size()), 0);
    check("r1_q_left", 32'(exp_r1_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
